// File: rtl/alt_vipvfr131_common_mode_decoder.sv
// Binary mode code -> registered one-hot enable, with a guard/drain gap on every
// real mode change so the old enable always drops before the new one asserts.

module alt_vipvfr131_common_mode_decoder_bit #(
  parameter int LOG2_NO_OF_MODES = 2,
  parameter int IDX              = 0
) (
  input  logic [LOG2_NO_OF_MODES-1:0] code,
  output logic                        hit
);
  localparam logic [LOG2_NO_OF_MODES-1:0] IDX_CODE = LOG2_NO_OF_MODES'(IDX + 1);
  assign hit = (code == IDX_CODE);
endmodule

module alt_vipvfr131_common_mode_decoder #(
  parameter int NO_OF_MODES      = 3,
  parameter int LOG2_NO_OF_MODES = 2,
  parameter int GUARD_CYCLES     = 4,
  parameter int GUARD_WIDTH      = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [LOG2_NO_OF_MODES-1:0] req_mode,
  input  logic                        busy,
  output logic [NO_OF_MODES-1:0]      one_hot,
  output logic [LOG2_NO_OF_MODES-1:0] current_mode,
  output logic                        mode_valid,
  output logic                        bad_mode
);

  typedef enum logic {S_HOLD, S_DRAIN} state_t;

  localparam logic [LOG2_NO_OF_MODES:0] MAX_CODE   = (LOG2_NO_OF_MODES+1)'(NO_OF_MODES);
  localparam logic [GUARD_WIDTH-1:0]    GUARD_LOAD = GUARD_WIDTH'(GUARD_CYCLES);
  localparam logic [GUARD_WIDTH-1:0]    GUARD_ONE  = GUARD_WIDTH'(1);

  state_t                        state_q, state_d;
  logic [GUARD_WIDTH-1:0]        guard_q, guard_d;
  logic [LOG2_NO_OF_MODES-1:0]   pending_q, pending_d;
  logic [LOG2_NO_OF_MODES-1:0]   cur_q, cur_d;
  logic [NO_OF_MODES-1:0]        one_hot_q, one_hot_d;
  logic                          mode_valid_q, mode_valid_d;
  logic                          bad_q, bad_d;
  logic                          ready_q, ready_d;
  logic [NO_OF_MODES-1:0]        dec_w;

  // One comparator per enable bit; code 0 matches none of them.
  for (genvar i = 0; i < NO_OF_MODES; i++) begin : g_dec
    alt_vipvfr131_common_mode_decoder_bit #(
      .LOG2_NO_OF_MODES(LOG2_NO_OF_MODES),
      .IDX             (i)
    ) u_bit (
      .code(pending_q),
      .hit (dec_w[i])
    );
  end

  always_comb begin
    state_d      = state_q;
    guard_d      = guard_q;
    pending_d    = pending_q;
    cur_d        = cur_q;
    one_hot_d    = one_hot_q;
    mode_valid_d = mode_valid_q;
    bad_d        = 1'b0;
    ready_d      = ready_q;
    unique case (state_q)
      S_HOLD: begin
        if (req_valid && ready_q) begin
          if ({1'b0, req_mode} > MAX_CODE) begin
            bad_d = 1'b1;
          end else if (req_mode != cur_q) begin
            pending_d    = req_mode;
            one_hot_d    = '0;
            mode_valid_d = 1'b0;
            ready_d      = 1'b0;
            guard_d      = GUARD_LOAD;
            state_d      = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (guard_q != '0) begin
          guard_d = guard_q - GUARD_ONE;
        end else if (!busy) begin
          one_hot_d    = dec_w;
          cur_d        = pending_q;
          mode_valid_d = (pending_q != '0);
          ready_d      = 1'b1;
          state_d      = S_HOLD;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_HOLD;
      guard_q      <= '0;
      pending_q    <= '0;
      cur_q        <= '0;
      one_hot_q    <= '0;
      mode_valid_q <= 1'b0;
      bad_q        <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      guard_q      <= guard_d;
      pending_q    <= pending_d;
      cur_q        <= cur_d;
      one_hot_q    <= one_hot_d;
      mode_valid_q <= mode_valid_d;
      bad_q        <= bad_d;
      ready_q      <= ready_d;
    end
  end

  assign req_ready    = ready_q;
  assign one_hot      = one_hot_q;
  assign current_mode = cur_q;
  assign mode_valid   = mode_valid_q;
  assign bad_mode     = bad_q;

endmodule

// File: tb/tb_alt_vipvfr131_common_mode_decoder.sv
// Bench for the mode decoder: directed vector table, bad-code and reset-in-drain
// sequences, then random requests against a cycle model with invariant monitors.

module tb_alt_vipvfr131_common_mode_decoder;

  localparam int N1 = 3, L1 = 2, G = 4;
  localparam int N2 = 5, L2 = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst1, v1, b1, rdy1, mv1, bad1;
  logic [L1-1:0] m1, cur1;
  logic [N1-1:0] oh1;
  logic          rst2, v2, b2, rdy2, mv2, bad2;
  logic [L2-1:0] m2, cur2;
  logic [N2-1:0] oh2;

  alt_vipvfr131_common_mode_decoder #(.NO_OF_MODES(N1), .LOG2_NO_OF_MODES(L1),
    .GUARD_CYCLES(G), .GUARD_WIDTH(3)) dut1 (
    .clock(clock), .reset(rst1), .req_valid(v1), .req_ready(rdy1), .req_mode(m1),
    .busy(b1), .one_hot(oh1), .current_mode(cur1), .mode_valid(mv1), .bad_mode(bad1));

  alt_vipvfr131_common_mode_decoder #(.NO_OF_MODES(N2), .LOG2_NO_OF_MODES(L2),
    .GUARD_CYCLES(G), .GUARD_WIDTH(3)) dut2 (
    .clock(clock), .reset(rst2), .req_valid(v2), .req_ready(rdy2), .req_mode(m2),
    .busy(b2), .one_hot(oh2), .current_mode(cur2), .mode_valid(mv2), .bad_mode(bad2));

  int checks = 0;
  int errors = 0;

  // Reference model of dut1: the mode shown, or a drain in progress toward a pending mode.
  bit md_drain;
  int md_cnt, md_pend, md_mode;
  bit md_bad;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic int enc(input logic [N1-1:0] oh);
    for (int i = 0; i < N1; i++) if (oh[i]) return i + 1;
    return 0;
  endfunction

  function automatic int exp_oh();
    if (md_drain || md_mode == 0) return 0;
    return 1 << (md_mode - 1);
  endfunction

  task automatic model_edge();
    md_bad = 1'b0;
    if (rst1) begin
      md_drain = 0; md_cnt = 0; md_pend = 0; md_mode = 0;
    end else if (md_drain) begin
      if (md_cnt > 0) md_cnt--;
      else if (!b1) begin md_mode = md_pend; md_drain = 0; end
    end else if (v1) begin
      if (int'(m1) > N1) md_bad = 1'b1;
      else if (int'(m1) != md_mode) begin
        md_drain = 1; md_cnt = G; md_pend = int'(m1);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_one_hot"}, int'(oh1), exp_oh());
    chk({tag, "_current_mode"}, int'(cur1), md_mode);
    chk({tag, "_mode_valid"}, int'(mv1), int'(exp_oh() != 0));
    chk({tag, "_req_ready"}, int'(rdy1), int'(!md_drain));
    chk({tag, "_bad_mode"}, int'(bad1), int'(md_bad));
  endtask

  task automatic check_inv();
    chk("inv_onehot", int'($countones(oh1) <= 1), 1);
    chk("inv_mode_valid", int'(mv1), int'(|oh1));
    if (mv1) chk("inv_roundtrip", enc(oh1), int'(cur1));
  endtask

  typedef struct {
    bit v; int m; bit b; int n;
    int oh; int cur; int mv; int rdy;
  } vec_t;
  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 2, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 4, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 2, 2, 1, 1};
    tbl[3]  = '{1, 2, 0, 1, 2, 2, 1, 1};
    tbl[4]  = '{1, 3, 1, 1, 0, 2, 0, 0};
    tbl[5]  = '{0, 0, 1, 4, 0, 2, 0, 0};
    tbl[6]  = '{0, 0, 1, 5, 0, 2, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 4, 3, 1, 1};
    tbl[8]  = '{1, 0, 0, 1, 0, 3, 0, 0};
    tbl[9]  = '{0, 0, 0, 4, 0, 3, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 0, 0, 0, 1};

    rst1 = 1; v1 = 0; m1 = '0; b1 = 0;
    rst2 = 1; v2 = 0; m2 = '0; b2 = 0;
    md_drain = 0; md_cnt = 0; md_pend = 0; md_mode = 0; md_bad = 0;

    // Reset held three cycles, then one idle cycle after release.
    repeat (3) tick();
    rst1 = 0; rst2 = 0;
    tick();
    chk("rst_one_hot", int'(oh1), 0);
    chk("rst_current_mode", int'(cur1), 0);
    chk("rst_mode_valid", int'(mv1), 0);
    chk("rst_req_ready", int'(rdy1), 1);
    chk("rst_bad_mode", int'(bad1), 0);

    // Wide instance: select mode 4, then out-of-range codes 6 and 7.
    v2 = 1; m2 = 3'd4;
    tick();
    v2 = 0;
    repeat (G + 1) tick();
    chk("wide_one_hot", int'(oh2), 8);
    chk("wide_current_mode", int'(cur2), 4);
    for (int c = 6; c <= 7; c++) begin
      v2 = 1; m2 = 3'(c);
      tick();
      v2 = 0;
      chk("bad_pulse", int'(bad2), 1);
      chk("bad_one_hot_kept", int'(oh2), 8);
      chk("bad_current_kept", int'(cur2), 4);
      chk("bad_ready_kept", int'(rdy2), 1);
      tick();
      chk("bad_pulse_end", int'(bad2), 0);
      chk("bad_one_hot_kept2", int'(oh2), 8);
    end

    // Directed vector table: guard timing, busy stall, same-mode request, mode 0.
    for (int r = 0; r < 11; r++) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        v1 = tbl[r].v; m1 = L1'(tbl[r].m); b1 = tbl[r].b;
        tick();
        chk($sformatf("vec%0d_one_hot", r), int'(oh1), tbl[r].oh);
        chk($sformatf("vec%0d_current_mode", r), int'(cur1), tbl[r].cur);
        chk($sformatf("vec%0d_mode_valid", r), int'(mv1), tbl[r].mv);
        chk($sformatf("vec%0d_req_ready", r), int'(rdy1), tbl[r].rdy);
        chk($sformatf("vec%0d_bad_mode", r), int'(bad1), 0);
      end
    end
    v1 = 0; b1 = 0;

    // Reset two cycles into a drain toward mode 1: the pending code must vanish.
    v1 = 1; m1 = 2'd1;
    tick();
    v1 = 0;
    chk("drain_entry_ready", int'(rdy1), 0);
    repeat (2) tick();
    rst1 = 1;
    tick();
    rst1 = 0;
    chk("mid_rst_one_hot", int'(oh1), 0);
    chk("mid_rst_current_mode", int'(cur1), 0);
    chk("mid_rst_mode_valid", int'(mv1), 0);
    chk("mid_rst_req_ready", int'(rdy1), 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("no_stale_001", int'(oh1 == 3'b001), 0);
      chk("post_rst_ready", int'(rdy1), 1);
    end

    // Random requests with random busy, holding each request until it is taken.
    begin
      int reqs = 0;
      int cyc = 0;
      bit taken;
      while (reqs < 1000 && cyc < 60000) begin
        if (!v1 && $urandom_range(0, 2) != 0) begin
          v1 = 1; m1 = L1'($urandom_range(0, 3));
        end
        b1 = ($urandom_range(0, 9) < 3);
        taken = v1 && !md_drain;
        tick();
        cyc++;
        check_model("rnd");
        check_inv();
        if (taken) begin v1 = 0; reqs++; end
      end
      chk("rnd_all_requests_taken", reqs, 1000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
